// File: rtl/seq_word_comparator_pkg.sv
// Shared types for the sequential word comparator.
// Chunk width, FSM state encoding and the lt/eq/gt result bundle.
package seq_cmp_pkg;

   localparam int CHUNK_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } cmp_res_t;

endpackage

// File: rtl/seq_word_comparator_if.sv
// Request/result bundle between the operand stage and the comparator.
// master drives start/a/b; slave returns busy/done and the flags.
interface seq_word_comparator_if #(
   parameter int WIDTH = 12
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             lt;
   logic             eq;
   logic             gt;

   modport master (
      output start, a, b,
      input  busy, done, lt, eq, gt
   );

   modport slave (
      input  start, a, b,
      output busy, done, lt, eq, gt
   );

endinterface

// File: rtl/seq_word_comparator_cmp3_slice.sv
// Cascadable 3-bit magnitude slice: an equal chunk passes the
// incoming l/e/g through, an unequal chunk replaces them.
module cmp3_slice (
   input  logic [2:0] a,
   input  logic [2:0] b,
   input  logic       l,
   input  logic       e,
   input  logic       g,
   output logic       lt,
   output logic       et,
   output logic       gt
);

   always_comb begin
      lt = l;
      et = e;
      gt = g;
      if (a < b) begin
         lt = 1'b1;
         et = 1'b0;
         gt = 1'b0;
      end else if (a > b) begin
         lt = 1'b0;
         et = 1'b0;
         gt = 1'b1;
      end
   end

endmodule

// File: rtl/seq_word_comparator.sv
// Multi-cycle WIDTH-bit comparator, one 3-bit chunk per cycle, LSB first.
// Define SEQ_CMP_SIGNED_EN for a two's complement compare.
module seq_word_comparator
   import seq_cmp_pkg::*;
#(
   parameter int WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seq_word_comparator_if.slave  bus
);

   localparam int NCHUNK = WIDTH / CHUNK_W;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   cmp_res_t         res_q, res_d;

   logic [WIDTH-1:0] a_in, b_in;
   logic [2:0]       ca, cb;
   logic             sl_lt, sl_et, sl_gt;

`ifdef SEQ_CMP_SIGNED_EN
   // Flipping the sign bit maps two's complement onto unsigned order.
   localparam logic [WIDTH-1:0] MSB_M = {1'b1, {(WIDTH-1){1'b0}}};
   assign a_in = bus.a ^ MSB_M;
   assign b_in = bus.b ^ MSB_M;
`else
   assign a_in = bus.a;
   assign b_in = bus.b;
`endif

   assign ca = a_q[int'(idx_q)*CHUNK_W +: CHUNK_W];
   assign cb = b_q[int'(idx_q)*CHUNK_W +: CHUNK_W];

   cmp3_slice u_slice (
      .a  (ca),
      .b  (cb),
      .l  (res_q.lt),
      .e  (res_q.eq),
      .g  (res_q.gt),
      .lt (sl_lt),
      .et (sl_et),
      .gt (sl_gt)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      unique case (state_q)
         RUN: begin
            res_d = '{lt: sl_lt, eq: sl_et, gt: sl_gt};
            if (idx_q == LAST) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         IDLE, DONE: begin
            if (state_q == DONE) state_d = IDLE;
            if (bus.start) begin
               state_d = RUN;
               idx_d   = '0;
               a_d     = a_in;
               b_d     = b_in;
               res_d   = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.lt   = res_q.lt;
   assign bus.eq   = res_q.eq;
   assign bus.gt   = res_q.gt;

endmodule

// File: tb/tb_seq_word_comparator.sv
// Scoreboard bench for seq_word_comparator (WIDTH=12).
// Honours SEQ_CMP_SIGNED_EN in its reference model.
module tb_seq_word_comparator;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   exp_t sb[$];

   seq_word_comparator_if #(.WIDTH(12)) bus ();

   seq_word_comparator #(.WIDTH(12)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input logic [11:0] a, input logic [11:0] b);
      exp_t r;
`ifdef SEQ_CMP_SIGNED_EN
      r.lt = $signed(a) < $signed(b);
      r.gt = $signed(a) > $signed(b);
`else
      r.lt = a < b;
      r.gt = a > b;
`endif
      r.eq = (a == b);
      return r;
   endfunction

   // Every done pulse must retire exactly one queued expectation.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         if (sb.size() == 0) begin
            chk("sb_empty_on_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_lt", int'(bus.lt), int'(e.lt));
            chk("res_eq", int'(bus.eq), int'(e.eq));
            chk("res_gt", int'(bus.gt), int'(e.gt));
         end
      end
   end

   task automatic launch(input logic [11:0] a, input logic [11:0] b);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      sb.push_back(model(a, b));
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int cyc, output int busy_n);
      cyc    = 1;
      busy_n = 0;
      while (!bus.done && cyc < 20) begin
         if (bus.busy) busy_n++;
         @(negedge clk);
         cyc++;
      end
      if (!bus.done) chk("done_timeout", 0, 1);
   endtask

   task automatic run_one(input string tag, input logic [11:0] a,
                          input logic [11:0] b);
      int   cyc, bn;
      exp_t e;
      e = model(a, b);
      launch(a, b);
      wait_done(cyc, bn);
      chk({tag, "_latency"}, cyc, 5);
      chk({tag, "_busy_cycles"}, bn, 4);
      @(negedge clk);
      chk({tag, "_done_1cyc"}, int'(bus.done), 0);
      chk({tag, "_hold"}, int'({bus.lt, bus.eq, bus.gt}), int'(e));
   endtask

   initial begin
      int   cyc, bn;
      n_tests   = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_flags", int'({bus.lt, bus.eq, bus.gt}), 0);
      rst_n = 1'b1;
      @(negedge clk);

      run_one("eq_5a3", 12'h5A3, 12'h5A3);
      run_one("lt_001", 12'h001, 12'h002);
      run_one("gt_400", 12'h400, 12'h3FF);
      run_one("msb_800", 12'h800, 12'h7FF);
      run_one("neg1_0", 12'hFFF, 12'h000);
      run_one("hi_chunk", 12'h0FF, 12'h100);

      // start while busy must be ignored
      launch(12'h123, 12'h124);
      bus.start = 1'b1;
      bus.a     = 12'hFFF;
      bus.b     = 12'h000;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(cyc, bn);
      chk("ign_latency", cyc + 1, 5);
      chk("ign_lt", int'(bus.lt), 1);
      repeat (8) @(negedge clk);
      chk("ign_no_extra", sb.size(), 0);

      // reset in the middle of RUN abandons the compare
      launch(12'h321, 12'h123);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      sb.delete();
      chk("mid_rst_busy", int'(bus.busy), 0);
      chk("mid_rst_done", int'(bus.done), 0);
      chk("mid_rst_flags", int'({bus.lt, bus.eq, bus.gt}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      run_one("after_rst", 12'h321, 12'h123);

      // back-to-back: restart in the DONE cycle
      launch(12'h001, 12'h002);
      wait_done(cyc, bn);
      chk("b2b_first_lat", cyc, 5);
      launch(12'h010, 12'h001);
      chk("b2b_done_drop", int'(bus.done), 0);
      wait_done(cyc, bn);
      chk("b2b_gap", cyc, 5);
      chk("b2b_gt", int'(bus.gt), 1);
      @(negedge clk);
      chk("b2b_sb_drained", sb.size(), 0);

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
